// File: rtl/uplus_40g_eth_pkg.sv
// rtl/uplus_40g_eth_pkg.sv - shared constants, FSM states and keep-mask helper for the 40G tx generator
package uplus_40g_eth_pkg;
   localparam int C_AXIS_DW        = 256;
   localparam int C_AXIS_KW        = 32;
   localparam int C_BYTES_PER_BEAT = 32;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SEND,
      GAP,
      DONE
   } tx_state_e;

   // A zero remainder means the final beat is completely full.
   function automatic logic [C_AXIS_KW-1:0] keep_mask(input logic [4:0] remainder);
      logic [C_AXIS_KW-1:0] mask;
      if (remainder == 5'd0) begin
         mask = '1;
      end else begin
         mask = (32'd1 << remainder) - 32'd1;
      end
      return mask;
   endfunction
endpackage

// File: rtl/uplus_40g_axis_tx_gen_if.sv
// rtl/uplus_40g_axis_tx_gen_if.sv - tx AXI-Stream bundle between the frame generator and the MAC
interface uplus_40g_axis_tx_gen_if;
   import uplus_40g_eth_pkg::*;

   logic                 tvalid;
   logic                 tready;
   logic [C_AXIS_DW-1:0] tdata;
   logic                 tuser;
   logic [C_AXIS_KW-1:0] tkeep;
   logic                 tlast;

   modport master (output tvalid, tdata, tuser, tkeep, tlast, input tready);
   modport slave  (input tvalid, tdata, tuser, tkeep, tlast, output tready);
endinterface

// File: rtl/uplus_40g_tx_beat_builder.sv
// rtl/uplus_40g_tx_beat_builder.sv - maps header/sequence/payload bytes onto one 32-byte beat
module uplus_40g_tx_beat_builder
   import uplus_40g_eth_pkg::*;
#(
   parameter logic [47:0] P_DST_MAC  = 48'hFFFF_FFFF_FFFF,
   parameter logic [47:0] P_SRC_MAC  = 48'h0A01_0203_0405,
   parameter logic [15:0] P_ETH_TYPE = 16'h88B5
) (
   input  logic [9:0]           beat_idx,
   input  logic [15:0]          seq,
   input  logic [14:0]          len,
   output logic [C_AXIS_DW-1:0] tdata,
   output logic [C_AXIS_KW-1:0] tkeep
);
   logic [127:0] hdr;
   logic [14:0]  last_idx;
   logic [14:0]  k;

   assign hdr      = {P_DST_MAC, P_SRC_MAC, P_ETH_TYPE, seq};
   assign last_idx = (len - 15'd1) >> 5;

   // Frame byte 0 sits in the top byte of hdr; payload bytes carry their own offset.
   always_comb begin
      tkeep = (last_idx == {5'd0, beat_idx}) ? keep_mask(len[4:0]) : '1;
      tdata = '0;
      k     = '0;
      for (int i = 0; i < C_BYTES_PER_BEAT; i++) begin
         k = {beat_idx, i[4:0]};
         if (tkeep[i]) begin
            if (k < 15'd16) begin
               tdata[8*i +: 8] = hdr[8*(15 - int'(k[3:0])) +: 8];
            end else begin
               tdata[8*i +: 8] = k[7:0];
            end
         end
      end
   end
endmodule

// File: rtl/uplus_40g_axis_tx_gen.sv
// rtl/uplus_40g_axis_tx_gen.sv - AXI-Stream Ethernet test frame generator for the 40G MAC tx port
module uplus_40g_axis_tx_gen
   import uplus_40g_eth_pkg::*;
#(
   parameter logic [7:0]  P_MIN_LENGTH = 8'd64,
   parameter logic [14:0] P_MAX_LENGTH = 15'd9600,
   parameter logic [47:0] P_DST_MAC    = 48'hFFFF_FFFF_FFFF,
   parameter logic [47:0] P_SRC_MAC    = 48'h0A01_0203_0405,
   parameter logic [15:0] P_ETH_TYPE   = 16'h88B5,
   parameter logic [7:0]  P_IFG_CYCLES = 8'd0
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_stop,
   input  logic [14:0] i_pkt_len,
   input  logic [15:0] i_pkt_num,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_pkt_cnt,
   uplus_40g_axis_tx_gen_if.master tx_axis
);
   tx_state_e            state, state_nxt;
   logic [14:0]          len_r, len_c;
   logic [9:0]           beats_r, beat_idx;
   logic [15:0]          seq, pkt_num_r;
   logic [7:0]           gap_cnt;
   logic                 stop_r, accept, last_beat, frame_end, run_end;
   logic [C_AXIS_DW-1:0] beat_data;
   logic [C_AXIS_KW-1:0] beat_keep;

   always_comb begin
      if (i_pkt_len < {7'd0, P_MIN_LENGTH}) begin
         len_c = {7'd0, P_MIN_LENGTH};
      end else if (i_pkt_len > P_MAX_LENGTH) begin
         len_c = P_MAX_LENGTH;
      end else begin
         len_c = i_pkt_len;
      end
   end

   assign accept    = tx_axis.tvalid && tx_axis.tready;
   assign last_beat = (beat_idx == beats_r - 10'd1);
   assign frame_end = accept && last_beat;
   // Quota mode ignores stop; continuous mode ends only at a frame boundary.
   assign run_end   = (pkt_num_r != 16'd0) ? (o_pkt_cnt + 32'd1 == {16'd0, pkt_num_r})
                                           : (stop_r || i_stop);

   always_comb begin
      state_nxt      = state;
      o_busy         = 1'b0;
      o_done         = 1'b0;
      tx_axis.tvalid = 1'b0;
      unique case (state)
         IDLE: if (i_start) state_nxt = LOAD;
         LOAD: begin
            o_busy    = 1'b1;
            state_nxt = SEND;
         end
         SEND: begin
            o_busy         = 1'b1;
            tx_axis.tvalid = 1'b1;
            if (frame_end) begin
               if (run_end)                     state_nxt = DONE;
               else if (P_IFG_CYCLES == 8'd0)   state_nxt = LOAD;
               else                             state_nxt = GAP;
            end
         end
         GAP: begin
            o_busy = 1'b1;
            if (gap_cnt == P_IFG_CYCLES - 8'd1) state_nxt = LOAD;
         end
         DONE: begin
            o_done    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= IDLE;
         len_r     <= '0;
         beats_r   <= '0;
         beat_idx  <= '0;
         seq       <= '0;
         pkt_num_r <= '0;
         o_pkt_cnt <= '0;
         gap_cnt   <= '0;
         stop_r    <= 1'b0;
      end else begin
         state  <= state_nxt;
         stop_r <= (state == IDLE) ? 1'b0 : (stop_r | i_stop);
         case (state)
            IDLE: if (i_start) begin
               pkt_num_r <= i_pkt_num;
               o_pkt_cnt <= '0;
               seq       <= '0;
            end
            LOAD: begin
               len_r    <= len_c;
               beats_r  <= 10'((len_c + 15'd31) >> 5);
               beat_idx <= '0;
            end
            SEND: if (accept) begin
               if (last_beat) begin
                  o_pkt_cnt <= o_pkt_cnt + 32'd1;
                  seq       <= seq + 16'd1;
                  gap_cnt   <= '0;
               end else begin
                  beat_idx <= beat_idx + 10'd1;
               end
            end
            GAP: gap_cnt <= gap_cnt + 8'd1;
            default: ;
         endcase
      end
   end

   uplus_40g_tx_beat_builder #(
      .P_DST_MAC  (P_DST_MAC),
      .P_SRC_MAC  (P_SRC_MAC),
      .P_ETH_TYPE (P_ETH_TYPE)
   ) u_beat_builder (
      .beat_idx (beat_idx),
      .seq      (seq),
      .len      (len_r),
      .tdata    (beat_data),
      .tkeep    (beat_keep)
   );

   assign tx_axis.tdata = tx_axis.tvalid ? beat_data : '0;
   assign tx_axis.tkeep = tx_axis.tvalid ? beat_keep : '0;
   assign tx_axis.tlast = tx_axis.tvalid && last_beat;
   assign tx_axis.tuser = 1'b0;
endmodule

// File: tb/tb_uplus_40g_axis_tx_gen.sv
// tb/tb_uplus_40g_axis_tx_gen.sv - scoreboard bench for the 40G AXIS tx frame generator
module tb_uplus_40g_axis_tx_gen;
   localparam logic [47:0] DST   = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] SRC   = 48'h0A01_0203_0405;
   localparam logic [15:0] ETYPE = 16'h88B5;
   localparam int          IFG   = 4;

   typedef struct {
      logic [255:0] data;
      logic [31:0]  keep;
      logic         last;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [14:0] pkt_len = '0;
   logic [15:0] pkt_num = '0;
   logic        busy, done;
   logic [31:0] pkt_cnt;

   int     errors = 0;
   int     checks = 0;
   int     done_cnt = 0;
   int     rdy_mode = 0;
   int     ph = 0;
   bit     sb_en = 1'b1;
   beat_t  exp_q[$];
   int     gaps[$];

   uplus_40g_axis_tx_gen_if axis ();

   uplus_40g_axis_tx_gen #(
      .P_MIN_LENGTH (8'd64),
      .P_MAX_LENGTH (15'd9600),
      .P_DST_MAC    (DST),
      .P_SRC_MAC    (SRC),
      .P_ETH_TYPE   (ETYPE),
      .P_IFG_CYCLES (8'(IFG))
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_start   (start),
      .i_stop    (stop),
      .i_pkt_len (pkt_len),
      .i_pkt_num (pkt_num),
      .o_busy    (busy),
      .o_done    (done),
      .o_pkt_cnt (pkt_cnt),
      .tx_axis   (axis)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference frame: byte k of the frame, straight from the frame layout.
   function automatic logic [7:0] exp_byte(input int k, input int seq);
      if (k < 6)  return 8'(DST >> (8 * (5 - k)));
      if (k < 12) return 8'(SRC >> (8 * (11 - k)));
      if (k < 14) return 8'(ETYPE >> (8 * (13 - k)));
      if (k < 16) return 8'((seq & 16'hFFFF) >> (8 * (15 - k)));
      return 8'(k % 256);
   endfunction

   task automatic push_frame(input int req, input int seq);
      int    len;
      int    beats;
      beat_t b;
      len   = (req < 64) ? 64 : ((req > 9600) ? 9600 : req);
      beats = (len + 31) / 32;
      for (int bi = 0; bi < beats; bi++) begin
         b.data = '0;
         b.keep = '0;
         for (int i = 0; i < 32; i++) begin
            if (bi * 32 + i < len) begin
               b.keep[i]       = 1'b1;
               b.data[8*i +: 8] = exp_byte(bi * 32 + i, seq);
            end
         end
         b.last = (bi == beats - 1);
         exp_q.push_back(b);
      end
   endtask

   initial begin
      axis.tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       axis.tready = 1'b1;
            1:       axis.tready = (ph % 4 == 0) || (ph % 4 == 3);
            default: axis.tready = 1'($urandom_range(0, 1));
         endcase
         ph++;
      end
   end

   initial begin
      beat_t        e;
      bit           stall_prev;
      bit           gap_run;
      int           idle;
      logic [255:0] prev_data;
      logic [31:0]  prev_keep;
      logic         prev_last;
      stall_prev = 1'b0;
      gap_run    = 1'b0;
      idle       = 0;
      forever begin
         @(negedge clk);
         if (done) done_cnt++;
         if (rst || !sb_en) begin
            stall_prev = 1'b0;
            gap_run    = 1'b0;
         end else begin
            if (stall_prev) begin
               chk("stall_data", axis.tdata, prev_data);
               chk("stall_ctl", {axis.tvalid, axis.tlast, axis.tkeep}, {1'b1, prev_last, prev_keep});
            end
            if (gap_run) begin
               if (axis.tvalid) begin
                  gaps.push_back(idle);
                  gap_run = 1'b0;
               end else begin
                  idle++;
               end
            end
            if (axis.tvalid && axis.tready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat actual=beat_accepted required=no_beat");
               end else begin
                  e = exp_q.pop_front();
                  chk("beat_data", axis.tdata, e.data);
                  chk("beat_keep", axis.tkeep, e.keep);
                  chk("beat_last_user", {axis.tlast, axis.tuser}, {e.last, 1'b0});
               end
               if (axis.tlast) begin
                  gap_run = 1'b1;
                  idle    = 0;
               end
            end
            if (done) gap_run = 1'b0;
            stall_prev = axis.tvalid && !axis.tready;
            prev_data  = axis.tdata;
            prev_keep  = axis.tkeep;
            prev_last  = axis.tlast;
         end
      end
   end

   task automatic start_run(input int len, input int num);
      @(posedge clk);
      #1;
      pkt_len = 15'(len);
      pkt_num = 16'(num);
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("load_busy_tvalid", {busy, axis.tvalid}, 2'b10);
      @(posedge clk);
      #1;
      chk("first_tvalid", axis.tvalid, 1'b1);
   endtask

   task automatic wait_done(input int budget);
      int d0;
      int n;
      d0 = done_cnt;
      n  = 0;
      while (done_cnt == d0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (done_cnt == d0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=no_o_done_after_%0d_cycles required=o_done", n);
      end
      repeat (4) @(posedge clk);
      #1;
      chk("done_pulses", 32'(done_cnt - d0), 1);
      chk("busy_after_done", busy, 1'b0);
   endtask

   task automatic check_tail(input int num_frames);
      chk("pkt_cnt", pkt_cnt, 32'(num_frames));
      chk("queue_drained", 32'(exp_q.size()), 0);
      chk("gap_count", 32'(gaps.size()), 32'(num_frames - 1));
      foreach (gaps[i]) chk("gap_len", 32'(gaps[i]), IFG + 1);
      exp_q.delete();
   endtask

   task automatic run(input int len, input int num, input int mode);
      rdy_mode = mode;
      gaps.delete();
      for (int f = 0; f < num; f++) push_frame(len, f);
      start_run(len, num);
      wait_done(20000);
      check_tail(num);
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctl", {axis.tvalid, axis.tlast, axis.tuser, busy, done}, 5'b0);
      chk("rst_keep", axis.tkeep, 32'b0);
      chk("rst_data", axis.tdata, 256'b0);
      chk("rst_cnt", pkt_cnt, 32'b0);
      rst = 1'b0;

      run(64, 1, 0);
      run(65, 1, 2);
      run(10, 1, 1);
      run(10000, 1, 2);
      run(128, 3, 1);
      for (int r = 0; r < 4; r++) run($urandom_range(1, 700), $urandom_range(1, 3), 2);

      // Continuous run stopped while frame 5 is on the bus.
      rdy_mode = 0;
      gaps.delete();
      for (int f = 0; f < 5; f++) push_frame(100, f);
      start_run(100, 0);
      n = 0;
      while (!(pkt_cnt == 32'd4 && axis.tvalid) && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("reached_frame5", {31'd0, axis.tvalid}, 1);
      stop = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
      wait_done(2000);
      check_tail(5);

      // Reset while beat 1 of a 128-byte frame is presented.
      rdy_mode = 0;
      sb_en    = 1'b0;
      start_run(128, 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_ctl", {axis.tvalid, busy, done}, 3'b0);
      chk("midrst_cnt", pkt_cnt, 32'b0);
      rst = 1'b0;
      exp_q.delete();
      sb_en = 1'b1;
      run(64, 2, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog actual=still_running required=finished");
      $fatal(1, "watchdog expired");
   end
endmodule
